// File: rtl/phase_sum_pipe.sv
// Winding-phase accumulator: signs each pole/zero angle, sums them modulo one
// full turn through a registered adder tree, with a globally stalled valid/ready pipe.
module phase_sum_pipe #(
  parameter int N_TERMS = 2,
  parameter int PHASE_W = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_TERMS-1:0]         cfg_pole,
  input  logic [N_TERMS-1:0]         cfg_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_TERMS*PHASE_W-1:0] in_phase,
  input  logic                       in_first,
  input  logic                       in_lastx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PHASE_W-1:0]         out_phase,
  output logic                       out_first,
  output logic                       out_lastx
);

  localparam int LAT  = $clog2(N_TERMS) + 1;
  localparam int LVLS = LAT - 1;

  // Number of live partial sums after k pairwise-add levels.
  function automatic int unsigned level_cnt(input int unsigned k);
    return (N_TERMS + (1 << k) - 1) >> k;
  endfunction

  logic [PHASE_W-1:0] sum_q [LAT][N_TERMS];
  logic [LAT-1:0]     vld_q, first_q, lastx_q;
  logic [N_TERMS-1:0] pole_q, en_q, pole_eff, en_eff;
  logic [PHASE_W-1:0] term [N_TERMS];
  logic               adv, take, load_cfg;

  assign adv      = !vld_q[LVLS] || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;
  assign load_cfg = take && in_first;

  // A frame-start beat uses the configuration it latches, not the stale masks.
  always_comb begin
    pole_eff = load_cfg ? cfg_pole : pole_q;
    en_eff   = load_cfg ? cfg_en   : en_q;
    for (int unsigned i = 0; i < N_TERMS; i++) begin
      term[i] = en_eff[i] ? in_phase[i*PHASE_W +: PHASE_W] : '0;
      if (pole_eff[i])
        term[i] = -term[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      first_q <= '0;
      lastx_q <= '0;
      pole_q  <= '0;
      en_q    <= '1;
      for (int unsigned k = 0; k < LAT; k++)
        for (int unsigned j = 0; j < N_TERMS; j++)
          sum_q[k][j] <= '0;
    end else begin
      if (load_cfg) begin
        pole_q <= cfg_pole;
        en_q   <= cfg_en;
      end
      if (adv) begin
        vld_q[0]   <= in_valid;
        first_q[0] <= in_first;
        lastx_q[0] <= in_lastx;
        for (int unsigned i = 0; i < N_TERMS; i++)
          sum_q[0][i] <= term[i];
        for (int unsigned k = 1; k <= LVLS; k++) begin
          vld_q[k]   <= vld_q[k-1];
          first_q[k] <= first_q[k-1];
          lastx_q[k] <= lastx_q[k-1];
          for (int unsigned j = 0; j < N_TERMS; j++) begin
            if (j < level_cnt(k)) begin
              // An odd leftover operand is registered through unchanged.
              if (2*j + 1 < level_cnt(k-1))
                sum_q[k][j] <= sum_q[k-1][2*j] + sum_q[k-1][2*j+1];
              else
                sum_q[k][j] <= sum_q[k-1][2*j];
            end else begin
              sum_q[k][j] <= '0;
            end
          end
        end
      end
    end
  end

  assign out_valid = vld_q[LVLS];
  assign out_phase = sum_q[LVLS][0];
  assign out_first = first_q[LVLS];
  assign out_lastx = lastx_q[LVLS];

endmodule
